// File: rtl/and_gate_bist_ctrl.sv
// BIST sequencer for a single 2-input AND cell: walks {a,b} through 00..11,
// lets each pattern settle, samples the cell output and reports the results.
module and_gate_bist_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 3
) (
  input  logic             IN_clk,
  input  logic             IN_rst_n,
  input  logic             IN_start,
  input  logic             IN_x,
  output logic             OUT_a,
  output logic             OUT_b,
  output logic             OUT_busy,
  output logic             OUT_done,
  output logic             OUT_pass,
  output logic [ERR_W-1:0] OUT_err_cnt,
  output logic [3:0]       OUT_fail_vec
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  generate
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("and_gate_bist_ctrl: SETTLE_CYCLES must be at least 1");
    end
    if (ERR_W < 1) begin : g_bad_err_w
      $error("and_gate_bist_ctrl: ERR_W must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             a_next, b_next, busy_next, done_next, pass_next;
  logic [ERR_W-1:0] err_next;
  logic [3:0]       fail_next;

  // While a run is active the driven pattern {a,b} doubles as the pattern index.
  logic [1:0] pat;
  logic       mismatch;
  logic [3:0] fail_upd;

  assign pat      = {OUT_a, OUT_b};
  assign mismatch = IN_x != (OUT_a & OUT_b);
  assign fail_upd = OUT_fail_vec | ({3'b000, mismatch} << pat);

  always_ff @(posedge IN_clk) begin
    if (!IN_rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      OUT_a        <= 1'b0;
      OUT_b        <= 1'b0;
      OUT_busy     <= 1'b0;
      OUT_done     <= 1'b0;
      OUT_pass     <= 1'b0;
      OUT_err_cnt  <= '0;
      OUT_fail_vec <= '0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      OUT_a        <= a_next;
      OUT_b        <= b_next;
      OUT_busy     <= busy_next;
      OUT_done     <= done_next;
      OUT_pass     <= pass_next;
      OUT_err_cnt  <= err_next;
      OUT_fail_vec <= fail_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    a_next     = OUT_a;
    b_next     = OUT_b;
    busy_next  = OUT_busy;
    done_next  = 1'b0;
    pass_next  = OUT_pass;
    err_next   = OUT_err_cnt;
    fail_next  = OUT_fail_vec;

    case (state)
      IDLE: begin
        if (IN_start) begin
          a_next     = 1'b0;
          b_next     = 1'b0;
          busy_next  = 1'b1;
          pass_next  = 1'b0;
          err_next   = '0;
          fail_next  = '0;
          cnt_next   = CNT_LOAD;
          state_next = SETTLE;
        end
      end

      SETTLE: begin
        if (cnt == '0) begin
          state_next = SAMPLE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end

      SAMPLE: begin
        fail_next = fail_upd;
        if (mismatch && (OUT_err_cnt != ERR_MAX)) begin
          err_next = OUT_err_cnt + ERR_W'(1);
        end
        if (pat == 2'd3) begin
          a_next     = 1'b0;
          b_next     = 1'b0;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          pass_next  = (fail_upd == 4'b0000);
          state_next = DONE;
        end else begin
          {a_next, b_next} = pat + 2'd1;
          cnt_next         = CNT_LOAD;
          state_next       = SETTLE;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
